// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM state encoding, AXI response codes,
// reset vector and the {inst, pc} field layout that decode also relies on.
package core_pkg;

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT_R  = 2'd1,
    S_SEND    = 2'd2,
    S_WAIT_PC = 2'd3
  } ifu_state_t;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  // ifu_data layout: [INST_MSB:PC_MSB+1] = instruction, [PC_MSB:0] = pc
  localparam int INST_MSB = 63;
  localparam int PC_MSB   = 31;

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit for the multi-cycle core. Issues one read per
// instruction at pc, hands {inst, pc} to decode, then waits for write-back
// to commit the next pc. Only one instruction is ever in flight.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_REQ     | read address presented (arvalid), waiting for arready
// S_WAIT_R  | address accepted, waiting for read data (rready)
// S_SEND    | {inst, pc} offered to decode (ifu_valid), waiting idu_ready
// S_WAIT_PC | decode took the instruction, waiting for wbu commit
module ifu
  import core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ifu_valid,
  output logic [2*XLEN-1:0] ifu_data,
  input  logic              idu_ready,
  output logic              ifu_arvalid,
  output logic [XLEN-1:0]   ifu_araddr,
  input  logic              ifu_arready,
  input  logic              ifu_rvalid,
  input  logic [XLEN-1:0]   ifu_rdata,
  input  logic [1:0]        ifu_rresp,
  output logic              ifu_rready,
  input  logic              wbu_valid,
  input  logic [XLEN-1:0]   wbu_next_pc,
  output logic              ifu_err
);

  ifu_state_t      state;
  logic [XLEN-1:0] pc;

  // Fetch sequencing, pc update, captured instruction and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      ifu_data <= '0;
      ifu_err  <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (ifu_arready) state <= S_WAIT_R;
        end
        S_WAIT_R: begin
          if (ifu_rvalid) begin
            // A bad response is still forwarded; the trap logic downstream
            // decides what to do with it, we only record that it happened.
            ifu_data[INST_MSB:PC_MSB+1] <= ifu_rdata;
            ifu_data[PC_MSB:0]          <= pc;
            if (ifu_rresp != RESP_OKAY) ifu_err <= 1'b1;
            state <= S_SEND;
          end
        end
        S_SEND: begin
          if (idu_ready) state <= S_WAIT_PC;
        end
        S_WAIT_PC: begin
          if (wbu_valid) begin
            // Misaligned targets are fetched as-is so the address that
            // caused the fault is visible; the flag is what reports it.
            pc <= wbu_next_pc;
            if (wbu_next_pc[1:0] != 2'b00) ifu_err <= 1'b1;
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  // Handshake strobes are pure decodes of the state register.
  assign ifu_arvalid = (state == S_REQ);
  assign ifu_rready  = (state == S_WAIT_R);
  assign ifu_valid   = (state == S_SEND);
  assign ifu_araddr  = pc;

  // A commit outside S_WAIT_PC is dropped; make the upstream slip visible.
  a_wbu_in_wait_pc : assert property (@(posedge clk) disable iff (rst)
    wbu_valid |-> (state == S_WAIT_PC))
    else $info("ifu: wbu_valid outside S_WAIT_PC ignored");

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: scripted memory/decode/write-back stimulus,
// expected {inst, pc} words queued at read-data time and popped on ifu_valid.
module tb_ifu;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_valid;
  logic [63:0] ifu_data;
  logic        idu_ready;
  logic        ifu_arvalid;
  logic [31:0] ifu_araddr;
  logic        ifu_arready;
  logic        ifu_rvalid;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rready;
  logic        wbu_valid;
  logic [31:0] wbu_next_pc;
  logic        ifu_err;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_d;
  logic [63:0] held;
  logic [31:0] exp_pc;

  ifu dut (
    .clk        (clk),
    .rst        (rst),
    .ifu_valid  (ifu_valid),
    .ifu_data   (ifu_data),
    .idu_ready  (idu_ready),
    .ifu_arvalid(ifu_arvalid),
    .ifu_araddr (ifu_araddr),
    .ifu_arready(ifu_arready),
    .ifu_rvalid (ifu_rvalid),
    .ifu_rdata  (ifu_rdata),
    .ifu_rresp  (ifu_rresp),
    .ifu_rready (ifu_rready),
    .wbu_valid  (wbu_valid),
    .wbu_next_pc(wbu_next_pc),
    .ifu_err    (ifu_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory side of one fetch: address accepted after ar_delay cycles, data
  // returned the cycle after. Expected decode word is queued with the data.
  task automatic do_fetch(input int ar_delay, input logic [31:0] data, input logic [1:0] resp);
    ifu_arready = 1'b0;
    for (int i = 0; i < ar_delay; i++) tick();
    ifu_arready = 1'b1;
    tick();
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b1;
    ifu_rdata   = data;
    ifu_rresp   = resp;
    exp_q.push_back({data, exp_pc});
    tick();
    ifu_rvalid  = 1'b0;
    ifu_rresp   = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1; idu_ready = 1'b0; ifu_arready = 1'b0; ifu_rvalid = 1'b0;
    ifu_rdata = '0; ifu_rresp = 2'b00; wbu_valid = 1'b0; wbu_next_pc = '0;
    tick(); tick();
    checks++;
    if (ifu_valid !== 1'b0 || ifu_rready !== 1'b0) begin
      failures++; $display("FAIL reset_idle valid=%0b rready=%0b exp 0/0", ifu_valid, ifu_rready);
    end
    checks++;
    if (ifu_data !== 64'h0 || ifu_err !== 1'b0) begin
      failures++; $display("FAIL reset_regs data=%h err=%0b exp 0/0", ifu_data, ifu_err);
    end
    rst = 1'b0;
    tick();
    exp_pc = 32'h8000_0000;
    checks++;
    if (ifu_arvalid !== 1'b1 || ifu_araddr !== 32'h8000_0000 || ifu_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_req arvalid=%0b araddr=%h valid=%0b exp 1/80000000/0", ifu_arvalid, ifu_araddr, ifu_valid);
    end
  endtask

  task automatic test_fetch_delay();
    ifu_arready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ifu_arvalid !== 1'b1 || ifu_araddr !== exp_pc || ifu_valid !== 1'b0) begin
        failures++;
        $display("FAIL ar_hold cyc=%0d arvalid=%0b araddr=%h valid=%0b exp 1/%h/0", i, ifu_arvalid, ifu_araddr, ifu_valid, exp_pc);
      end
    end
    ifu_arready = 1'b1;
    tick();
    ifu_arready = 1'b0;
    checks++;
    if (ifu_rready !== 1'b1 || ifu_arvalid !== 1'b0 || ifu_valid !== 1'b0) begin
      failures++;
      $display("FAIL wait_r rready=%0b arvalid=%0b valid=%0b exp 1/0/0", ifu_rready, ifu_arvalid, ifu_valid);
    end
    ifu_rvalid = 1'b1; ifu_rdata = 32'h0000_0513; ifu_rresp = 2'b00;
    exp_q.push_back({32'h0000_0513, exp_pc});
    tick();
    ifu_rvalid = 1'b0;
    checks++;
    if (ifu_valid !== 1'b1 || ifu_rready !== 1'b0) begin
      failures++; $display("FAIL valid_latency valid=%0b rready=%0b exp 1/0", ifu_valid, ifu_rready);
    end
    exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
    checks++;
    if (ifu_data !== exp_d || ifu_data !== 64'h0000_0513_8000_0000) begin
      failures++; $display("FAIL first_data got=%h exp=%h", ifu_data, 64'h0000_0513_8000_0000);
    end
  endtask

  task automatic test_backpressure();
    held = ifu_data;
    idu_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ifu_valid !== 1'b1 || ifu_data !== held) begin
        failures++; $display("FAIL stall cyc=%0d valid=%0b data=%h exp 1/%h", i, ifu_valid, ifu_data, held);
      end
    end
    idu_ready = 1'b1;
    tick();
    idu_ready = 1'b0;
    checks++;
    if (ifu_valid !== 1'b0 || ifu_arvalid !== 1'b0) begin
      failures++; $display("FAIL accept_drop valid=%0b arvalid=%0b exp 0/0", ifu_valid, ifu_arvalid);
    end
  endtask

  task automatic test_commit();
    wbu_valid = 1'b1; wbu_next_pc = 32'h8000_0010;
    tick();
    wbu_valid = 1'b0;
    exp_pc = 32'h8000_0010;
    checks++;
    if (ifu_arvalid !== 1'b1 || ifu_araddr !== exp_pc) begin
      failures++; $display("FAIL commit_fetch arvalid=%0b araddr=%h exp 1/%h", ifu_arvalid, ifu_araddr, exp_pc);
    end
    do_fetch(0, 32'h0010_0093, 2'b00);
    exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
    checks++;
    if (ifu_valid !== 1'b1 || ifu_data !== exp_d) begin
      failures++; $display("FAIL commit_data valid=%0b got=%h exp=%h", ifu_valid, ifu_data, exp_d);
    end
    // commit while still offering to decode must be dropped
    idu_ready = 1'b0; wbu_valid = 1'b1; wbu_next_pc = 32'h8000_0040;
    tick();
    wbu_valid = 1'b0;
    checks++;
    if (ifu_valid !== 1'b1 || ifu_arvalid !== 1'b0) begin
      failures++; $display("FAIL wbu_in_send valid=%0b arvalid=%0b exp 1/0", ifu_valid, ifu_arvalid);
    end
    // commit in the same cycle as decode accept is also dropped
    idu_ready = 1'b1; wbu_valid = 1'b1; wbu_next_pc = 32'h8000_0080;
    tick();
    idu_ready = 1'b0; wbu_valid = 1'b0;
    tick();
    checks++;
    if (ifu_valid !== 1'b0 || ifu_arvalid !== 1'b0) begin
      failures++; $display("FAIL wbu_same_cycle valid=%0b arvalid=%0b exp 0/0", ifu_valid, ifu_arvalid);
    end
    wbu_valid = 1'b1; wbu_next_pc = 32'h8000_0014;
    tick();
    wbu_valid = 1'b0;
    exp_pc = 32'h8000_0014;
    checks++;
    if (ifu_arvalid !== 1'b1 || ifu_araddr !== exp_pc || ifu_err !== 1'b0) begin
      failures++;
      $display("FAIL late_commit arvalid=%0b araddr=%h err=%0b exp 1/%h/0", ifu_arvalid, ifu_araddr, ifu_err, exp_pc);
    end
  endtask

  task automatic test_err_resp();
    do_fetch(1, 32'hdead_beef, 2'b10);
    exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
    checks++;
    if (ifu_err !== 1'b1 || ifu_valid !== 1'b1 || ifu_data !== exp_d) begin
      failures++;
      $display("FAIL rresp_err err=%0b valid=%0b data=%h exp 1/1/%h", ifu_err, ifu_valid, ifu_data, exp_d);
    end
    idu_ready = 1'b1; tick(); idu_ready = 1'b0;
    wbu_valid = 1'b1; wbu_next_pc = 32'h8000_0018; tick(); wbu_valid = 1'b0;
    exp_pc = 32'h8000_0018;
    do_fetch(0, 32'h0000_0013, 2'b00);
    exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
    checks++;
    if (ifu_err !== 1'b1 || ifu_data !== exp_d) begin
      failures++; $display("FAIL err_sticky err=%0b data=%h exp 1/%h", ifu_err, ifu_data, exp_d);
    end
    idu_ready = 1'b1; tick(); idu_ready = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0; tick();
    exp_pc = 32'h8000_0000;
    checks++;
    if (ifu_err !== 1'b0 || ifu_data !== 64'h0 || ifu_araddr !== exp_pc) begin
      failures++;
      $display("FAIL err_clear err=%0b data=%h araddr=%h exp 0/0/%h", ifu_err, ifu_data, ifu_araddr, exp_pc);
    end
  endtask

  task automatic test_misaligned();
    do_fetch(2, 32'h0000_0013, 2'b00);
    exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
    checks++;
    if (ifu_data !== exp_d || ifu_err !== 1'b0) begin
      failures++; $display("FAIL pre_misalign data=%h err=%0b exp %h/0", ifu_data, ifu_err, exp_d);
    end
    idu_ready = 1'b1; tick(); idu_ready = 1'b0;
    wbu_valid = 1'b1; wbu_next_pc = 32'h8000_0002; tick(); wbu_valid = 1'b0;
    exp_pc = 32'h8000_0002;
    checks++;
    if (ifu_err !== 1'b1 || ifu_arvalid !== 1'b1 || ifu_araddr !== exp_pc) begin
      failures++;
      $display("FAIL misalign err=%0b arvalid=%0b araddr=%h exp 1/1/%h", ifu_err, ifu_arvalid, ifu_araddr, exp_pc);
    end
    do_fetch(0, 32'h00a0_0093, 2'b00);
    exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
    checks++;
    if (ifu_data !== exp_d || ifu_err !== 1'b1) begin
      failures++; $display("FAIL misalign_data data=%h err=%0b exp %h/1", ifu_data, ifu_err, exp_d);
    end
    idu_ready = 1'b1; tick(); idu_ready = 1'b0;
  endtask

  task automatic test_reset_inflight();
    wbu_valid = 1'b1; wbu_next_pc = 32'h8000_0020; tick(); wbu_valid = 1'b0;
    ifu_arready = 1'b1; tick(); ifu_arready = 1'b0;
    checks++;
    if (ifu_rready !== 1'b1) begin
      failures++; $display("FAIL inflight_wait_r rready=%0b exp 1", ifu_rready);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (ifu_valid !== 1'b0 || ifu_rready !== 1'b0) begin
      failures++; $display("FAIL inflight_rst valid=%0b rready=%0b exp 0/0", ifu_valid, ifu_rready);
    end
    rst = 1'b0;
    tick();
    exp_pc = 32'h8000_0000;
    checks++;
    if (ifu_arvalid !== 1'b1 || ifu_araddr !== exp_pc || ifu_valid !== 1'b0 || ifu_err !== 1'b0) begin
      failures++;
      $display("FAIL inflight_release arvalid=%0b araddr=%h valid=%0b err=%0b exp 1/%h/0/0", ifu_arvalid, ifu_araddr, ifu_valid, ifu_err, exp_pc);
    end
    // stray read data while only the address phase is open is ignored
    ifu_rvalid = 1'b1; ifu_rdata = 32'hffff_ffff;
    tick();
    ifu_rvalid = 1'b0;
    checks++;
    if (ifu_valid !== 1'b0 || ifu_arvalid !== 1'b1 || ifu_rready !== 1'b0) begin
      failures++;
      $display("FAIL stray_rvalid valid=%0b arvalid=%0b rready=%0b exp 0/1/0", ifu_valid, ifu_arvalid, ifu_rready);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] nxt;
    for (int n = 0; n < 4; n++) begin
      do_fetch(int'($urandom_range(0, 3)), $urandom, 2'b00);
      exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
      checks++;
      if (ifu_valid !== 1'b1 || ifu_data !== exp_d) begin
        failures++; $display("FAIL b2b_data n=%0d valid=%0b got=%h exp=%h", n, ifu_valid, ifu_data, exp_d);
      end
      idu_ready = 1'b1; tick(); idu_ready = 1'b0;
      nxt = exp_pc + 32'd4 + {$urandom_range(0, 7), 2'b00};
      wbu_valid = 1'b1; wbu_next_pc = nxt; tick(); wbu_valid = 1'b0;
      exp_pc = nxt;
      checks++;
      if (ifu_arvalid !== 1'b1 || ifu_araddr !== exp_pc) begin
        failures++; $display("FAIL b2b_addr n=%0d arvalid=%0b araddr=%h exp 1/%h", n, ifu_arvalid, ifu_araddr, exp_pc);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_fetch_delay();
    test_backpressure();
    test_commit();
    test_err_resp();
    test_misaligned();
    test_reset_inflight();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
